// File: rtl/pt_check_pkg.sv
// Shared types and helpers for the plaintext validator.
package pt_check_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] PRINT_MIN_DEF = 8'h20;
  localparam logic [BYTE_W-1:0] PRINT_MAX_DEF = 8'h7E;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  // Unsigned inclusive range test on one character byte.
  function automatic logic is_printable(input logic [BYTE_W-1:0] b,
                                        input logic [BYTE_W-1:0] lo,
                                        input logic [BYTE_W-1:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/pt_check.sv
// Scans the length-prefixed plaintext in pt_mem and reports whether every
// character byte is printable, plus the index of the first offending byte.
module pt_check
  import pt_check_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PRINT_MIN = PRINT_MIN_DEF,
  parameter logic [BYTE_W-1:0] PRINT_MAX = PRINT_MAX_DEF
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [BYTE_W-1:0] pt_addr,
  input  logic [BYTE_W-1:0] pt_rddata,
  output logic              valid,
  output logic [BYTE_W-1:0] bad_idx,
  output logic [BYTE_W-1:0] msg_len
);

  state_t            state_q, state_d;
  logic              len_ph_q, len_ph_d;
  logic [BYTE_W-1:0] idx_q, idx_d;
  logic [BYTE_W-1:0] pt_addr_q, pt_addr_d;
  logic              rdy_q, rdy_d;
  logic              valid_q, valid_d;
  logic [BYTE_W-1:0] bad_idx_q, bad_idx_d;
  logic [BYTE_W-1:0] msg_len_q, msg_len_d;

  // Next-state and datapath; the read address runs one byte ahead of the check.
  always_comb begin
    state_d   = state_q;
    len_ph_d  = len_ph_q;
    idx_d     = idx_q;
    pt_addr_d = pt_addr_q;
    rdy_d     = rdy_q;
    valid_d   = valid_q;
    bad_idx_d = bad_idx_q;
    msg_len_d = msg_len_q;

    case (state_q)
      IDLE, DONE: begin
        if (en) begin
          state_d   = LEN;
          len_ph_d  = 1'b0;
          pt_addr_d = '0;
          rdy_d     = 1'b0;
          valid_d   = 1'b0;
          bad_idx_d = '0;
        end
      end

      LEN: begin
        if (!len_ph_q) begin
          pt_addr_d = BYTE_W'(1);
          len_ph_d  = 1'b1;
        end else begin
          msg_len_d = pt_rddata;
          if (pt_rddata == '0) begin
            valid_d = 1'b1;
            rdy_d   = 1'b1;
            state_d = DONE;
          end else begin
            pt_addr_d = BYTE_W'(2);
            idx_d     = BYTE_W'(1);
            state_d   = SCAN;
          end
        end
      end

      SCAN: begin
        if (!is_printable(pt_rddata, PRINT_MIN, PRINT_MAX)) begin
          // Stop on the first bad byte; the address is frozen so nothing further is read.
          bad_idx_d = idx_q;
          valid_d   = 1'b0;
          rdy_d     = 1'b1;
          state_d   = DONE;
        end else begin
          pt_addr_d = BYTE_W'(pt_addr_q + BYTE_W'(1));
          idx_d     = BYTE_W'(idx_q + BYTE_W'(1));
          if (idx_q == msg_len_q) begin
            valid_d = 1'b1;
            rdy_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_ph_q  <= 1'b0;
      idx_q     <= '0;
      pt_addr_q <= '0;
      rdy_q     <= 1'b1;
      valid_q   <= 1'b0;
      bad_idx_q <= '0;
      msg_len_q <= '0;
    end else begin
      state_q   <= state_d;
      len_ph_q  <= len_ph_d;
      idx_q     <= idx_d;
      pt_addr_q <= pt_addr_d;
      rdy_q     <= rdy_d;
      valid_q   <= valid_d;
      bad_idx_q <= bad_idx_d;
      msg_len_q <= msg_len_d;
    end
  end

  assign rdy     = rdy_q;
  assign pt_addr = pt_addr_q;
  assign valid   = valid_q;
  assign bad_idx = bad_idx_q;
  assign msg_len = msg_len_q;

endmodule

// File: tb/tb_pt_check.sv
// Self-checking bench for pt_check: a scan-level model compared every cycle,
// plus directed vectors with literal expectations.
module tb_pt_check;

  logic       CLOCK_50;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic       valid;
  logic [7:0] bad_idx;
  logic [7:0] msg_len;

  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic saw4;
  int edges;

  pt_check dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .pt_addr  (pt_addr),
    .pt_rddata(pt_rddata),
    .valid    (valid),
    .bad_idx  (bad_idx),
    .msg_len  (msg_len)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // pt_mem with one cycle of read latency
  always @(posedge CLOCK_50) pt_rddata <= mem[pt_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-message verdict: end edge, validity and first bad index.
  function automatic void judge(output int end_e, output logic pv, output logic [7:0] pb);
    int l;
    l = int'(mem[0]);
    end_e = l + 2;
    pv = 1'b1;
    pb = 8'd0;
    for (int k = 1; k <= l; k++) begin
      if (mem[k] < 8'h20 || mem[k] > 8'h7E) begin
        end_e = k + 2;
        pv = 1'b0;
        pb = 8'(k);
        break;
      end
    end
  endfunction

  // Model state
  logic       m_busy;
  int         m_edge;
  int         m_end;
  logic       m_pv;
  logic [7:0] m_pb;
  logic [7:0] m_plen;
  logic       m_valid;
  logic [7:0] m_bad;
  logic [7:0] m_len;
  logic [7:0] m_addr;

  always @(posedge CLOCK_50 or negedge rst_n) begin
    int e_end;
    logic pv;
    logic [7:0] pb;
    int e;
    if (!rst_n) begin
      m_busy <= 1'b0; m_edge <= 0; m_end <= 0; m_pv <= 1'b0; m_pb <= 8'd0; m_plen <= 8'd0;
      m_valid <= 1'b0; m_bad <= 8'd0; m_len <= 8'd0; m_addr <= 8'd0;
    end else if (!m_busy) begin
      if (en) begin
        judge(e_end, pv, pb);
        m_busy <= 1'b1; m_edge <= 0; m_end <= e_end; m_pv <= pv; m_pb <= pb;
        m_plen <= mem[0]; m_valid <= 1'b0; m_bad <= 8'd0; m_addr <= 8'd0;
      end
    end else begin
      e = m_edge + 1;
      m_edge <= e;
      if (e == 1) m_addr <= 8'd1;
      else if (e == 2) m_addr <= (m_plen == 8'd0) ? 8'd1 : 8'd2;
      else if (!(e == m_end && !m_pv)) m_addr <= 8'(e);
      if (e == 2) m_len <= m_plen;
      if (e == m_end) begin
        m_busy <= 1'b0; m_valid <= m_pv; m_bad <= m_pb;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      check("cyc_rdy", 32'(rdy), 32'(!m_busy));
      check("cyc_pt_addr", 32'(pt_addr), 32'(m_addr));
      check("cyc_valid", 32'(valid), 32'(m_valid));
      check("cyc_bad_idx", 32'(bad_idx), 32'(m_bad));
      check("cyc_msg_len", 32'(msg_len), 32'(m_len));
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Start a scan and count edges until rdy returns; optional en pulse mid-scan.
  task automatic run(input int pulse_at, output int n);
    saw4 = 1'b0;
    @(negedge CLOCK_50); en = 1'b1;
    @(posedge CLOCK_50); n = 0;
    @(negedge CLOCK_50); en = 1'b0;
    check("rdy_fall", 32'(rdy), 32'd0);
    if (pt_addr == 8'd4) saw4 = 1'b1;
    while (rdy !== 1'b1 && n < 400) begin
      @(posedge CLOCK_50); n++;
      @(negedge CLOCK_50);
      en = (n == pulse_at);
      if (pt_addr == 8'd4) saw4 = 1'b1;
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    clear_mem();
    repeat (3) @(negedge CLOCK_50);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge CLOCK_50);
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_bad_idx", 32'(bad_idx), 32'd0);
    check("rst_msg_len", 32'(msg_len), 32'd0);
    check("rst_pt_addr", 32'(pt_addr), 32'd0);

    // {5,"Hello"}
    clear_mem();
    mem[0] = 8'd5; mem[1] = 8'h48; mem[2] = 8'h65; mem[3] = 8'h6C; mem[4] = 8'h6C; mem[5] = 8'h6F;
    run(-1, edges);
    check("hello_edges", 32'(edges), 32'd7);
    check("hello_valid", 32'(valid), 32'd1);
    check("hello_msg_len", 32'(msg_len), 32'd5);
    check("hello_bad_idx", 32'(bad_idx), 32'd0);
    check("hello_last_addr", 32'(pt_addr), 32'd7);
    check("model_hello_valid", 32'(m_valid), 32'd1);
    check("model_hello_len", 32'(m_len), 32'd5);

    // {4,'a',0x7F,'b','c'}
    clear_mem();
    mem[0] = 8'd4; mem[1] = 8'h61; mem[2] = 8'h7F; mem[3] = 8'h62; mem[4] = 8'h63;
    run(-1, edges);
    check("fail_edges", 32'(edges), 32'd4);
    check("fail_valid", 32'(valid), 32'd0);
    check("fail_bad_idx", 32'(bad_idx), 32'd2);
    check("fail_no_addr4", 32'(saw4), 32'd0);
    check("model_fail_bad", 32'(m_bad), 32'd2);

    // Empty message
    clear_mem();
    mem[0] = 8'd0;
    run(-1, edges);
    check("empty_edges", 32'(edges), 32'd2);
    check("empty_valid", 32'(valid), 32'd1);
    check("empty_msg_len", 32'(msg_len), 32'd0);

    // Range ends pass
    clear_mem();
    mem[0] = 8'd2; mem[1] = 8'h20; mem[2] = 8'h7E;
    run(-1, edges);
    check("edge_ok_edges", 32'(edges), 32'd4);
    check("edge_ok_valid", 32'(valid), 32'd1);

    // Just below the range
    clear_mem();
    mem[0] = 8'd1; mem[1] = 8'h1F;
    run(-1, edges);
    check("low_edges", 32'(edges), 32'd3);
    check("low_valid", 32'(valid), 32'd0);
    check("low_bad_idx", 32'(bad_idx), 32'd1);

    // High bit set
    clear_mem();
    mem[0] = 8'd1; mem[1] = 8'h80;
    run(-1, edges);
    check("high_edges", 32'(edges), 32'd3);
    check("high_valid", 32'(valid), 32'd0);
    check("high_bad_idx", 32'(bad_idx), 32'd1);

    // Longest message, address wraps past 255
    for (int i = 1; i < 256; i++) mem[i] = 8'h41;
    mem[0] = 8'd255;
    run(-1, edges);
    check("long_edges", 32'(edges), 32'd257);
    check("long_valid", 32'(valid), 32'd1);
    check("long_msg_len", 32'(msg_len), 32'd255);
    check("long_addr_wrap", 32'(pt_addr), 32'd1);

    // en pulsed while busy is ignored
    clear_mem();
    mem[0] = 8'd5; mem[1] = 8'h48; mem[2] = 8'h65; mem[3] = 8'h6C; mem[4] = 8'h6C; mem[5] = 8'h6F;
    run(3, edges);
    check("pulse_edges", 32'(edges), 32'd7);
    check("pulse_valid", 32'(valid), 32'd1);
    check("pulse_msg_len", 32'(msg_len), 32'd5);

    // Reset in the middle of a scan
    @(negedge CLOCK_50); en = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50); en = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1 rst_n = 1'b0;
    @(negedge CLOCK_50);
    check("mid_rst_rdy", 32'(rdy), 32'd1);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_bad_idx", 32'(bad_idx), 32'd0);
    check("mid_rst_msg_len", 32'(msg_len), 32'd0);
    check("mid_rst_pt_addr", 32'(pt_addr), 32'd0);
    rst_n = 1'b1;

    // Full scan after reset
    clear_mem();
    mem[0] = 8'd3; mem[1] = 8'h61; mem[2] = 8'h62; mem[3] = 8'h63;
    run(-1, edges);
    check("post_rst_edges", 32'(edges), 32'd5);
    check("post_rst_valid", 32'(valid), 32'd1);
    check("post_rst_msg_len", 32'(msg_len), 32'd3);

    repeat (2) @(negedge CLOCK_50);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
